// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synth voice path: keypad width, oscillator period
// width, voice FSM state type, the equal-tempered period table and a
// highest-set-bit helper used by the key arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package synth_pkg;

    localparam int NUM_KEYS = 15;
    localparam int PERIOD_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        CHANGE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Oscillator period in 10 MHz clock cycles for key i (C4 + i semitones).
    // Anchored on A4 = 22728: period_i = round(22728 * 2^((9 - i) / 12)).
    localparam logic [PERIOD_W-1:0] period_tbl [NUM_KEYS] = '{
        16'd38224, 16'd36078, 16'd34054, 16'd32142, 16'd30338,
        16'd28635, 16'd27028, 16'd25511, 16'd24079, 16'd22728,
        16'd21452, 16'd20248, 16'd19112, 16'd18039, 16'd17027
    };

    function automatic logic [3:0] highest_set_bit(input logic [NUM_KEYS-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/voice_ctrl_if.sv
// -----------------------------------------------------------------------------
// voice_ctrl_if
// Bundles the voice controller's keypad/oscillator-side signals.
//   en        voice enable (master -> slave)
//   keypad_i  raw key vector, asynchronous (master -> slave)
//   wrap_i    oscillator end-of-period strobe (master -> slave)
//   period_o  oscillator period (slave -> master)
//   note_o    sounding key index (slave -> master)
//   gate_o    voice sounding (slave -> master)
//   load_o    period update pulse (slave -> master)
// modport master: the environment driving the controller.
// modport slave:  the controller itself.
// -----------------------------------------------------------------------------
interface voice_ctrl_if;
    import synth_pkg::*;

    logic                en;
    logic [NUM_KEYS-1:0] keypad_i;
    logic                wrap_i;
    logic [PERIOD_W-1:0] period_o;
    logic [3:0]          note_o;
    logic                gate_o;
    logic                load_o;

    modport master (
        output en, keypad_i, wrap_i,
        input  period_o, note_o, gate_o, load_o
    );

    modport slave (
        input  en, keypad_i, wrap_i,
        output period_o, note_o, gate_o, load_o
    );
endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser followed by a stability down-counter. keys_stable
// takes the synced vector only after it has held the same value for
// DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
// Press-to-accept latency is 2 + DEBOUNCE_CYCLES cycles.
//   clk          system clock
//   rst          asynchronous, active-high reset
//   keys_raw     raw asynchronous key vector
//   keys_stable  debounced key vector
// -----------------------------------------------------------------------------
module key_debounce
    import synth_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] keys_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [CNT_W-1:0]    cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            cnt         <= '0;
            keys_stable <= '0;
        end else begin
            sync1 <= keys_raw;
            sync2 <= sync1;
            // sync1 differing from sync2 means sync2 changes at this edge,
            // so the stability window starts over.
            if (sync1 != sync2) begin
                cnt <= CNT_W'(DEBOUNCE_CYCLES - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else begin
                keys_stable <= sync2;
            end
        end
    end

endmodule

// File: rtl/voice_ctrl.sv
// -----------------------------------------------------------------------------
// voice_ctrl
// Monophonic voice controller: debounces the keypad, arbitrates held keys
// (last pressed wins, highest index on ties) and drives the oscillator period,
// note index and gate. Period changes while sounding are applied only on the
// oscillator wrap strobe so the PWM never emits a truncated cycle.
// Optional feature macro: PORTAMENTO_EN (glide toward the new period by
// GLIDE_STEP per wrap instead of jumping).
//   clk  10 MHz system clock
//   rst  asynchronous, active-high reset
//   vif  voice_ctrl_if.slave: en, keypad_i, wrap_i in; period_o, note_o,
//        gate_o, load_o out (all outputs registered)
//
// state   | meaning
// IDLE    | silent; period_o/note_o hold last value
// PLAY    | sounding the selected key
// CHANGE  | new key selected, waiting for wrap_i to apply it
// RELEASE | all keys up, gate held until the current period ends
// -----------------------------------------------------------------------------
module voice_ctrl
    import synth_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10000
`ifdef PORTAMENTO_EN
  , parameter int GLIDE_STEP      = 64
`endif
) (
    input  logic         clk,
    input  logic         rst,
    voice_ctrl_if.slave  vif
);

    logic [NUM_KEYS-1:0] keys_stable;
    logic [NUM_KEYS-1:0] keys_eff;
    logic [NUM_KEYS-1:0] keys_prev;
    logic [NUM_KEYS-1:0] rising;
    logic [3:0]          sel;
    logic [3:0]          sel_q;
    logic                sel_new;
    logic                all_released;
    logic [PERIOD_W-1:0] target;

    state_t              state;
    logic [PERIOD_W-1:0] period_q;
    logic [3:0]          note_q;
    logic                gate_q;
    logic                load_q;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .keys_raw    (vif.keypad_i),
        .keys_stable (keys_stable)
    );

    // Keys are masked while disabled, so anything still held when en rises
    // shows up as a rising edge and is treated as a fresh press.
    always_comb begin
        keys_eff     = vif.en ? keys_stable : '0;
        rising       = keys_eff & ~keys_prev;
        all_released = (keys_eff == '0);
        sel          = '0;
        sel_new      = 1'b0;
        if (rising != '0) begin
            sel     = highest_set_bit(rising);
            sel_new = 1'b1;
        end else if (!all_released && !keys_eff[sel_q]) begin
            sel     = highest_set_bit(keys_eff);
            sel_new = 1'b1;
        end
    end

    assign target = period_tbl[sel_q];

`ifdef PORTAMENTO_EN
    logic [PERIOD_W-1:0] glide_next;

    always_comb begin
        glide_next = target;
        if (period_q < target) begin
            if (target - period_q > PERIOD_W'(GLIDE_STEP)) glide_next = period_q + PERIOD_W'(GLIDE_STEP);
        end else begin
            if (period_q - target > PERIOD_W'(GLIDE_STEP)) glide_next = period_q - PERIOD_W'(GLIDE_STEP);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            period_q  <= '0;
            note_q    <= '0;
            gate_q    <= 1'b0;
            load_q    <= 1'b0;
            keys_prev <= '0;
            sel_q     <= '0;
        end else begin
            keys_prev <= keys_eff;
            load_q    <= 1'b0;
            if (sel_new) sel_q <= sel;

            if (!vif.en) begin
                state  <= IDLE;
                gate_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sel_new) begin
                            gate_q   <= 1'b1;
                            period_q <= period_tbl[sel];
                            note_q   <= sel;
                            load_q   <= 1'b1;
                            state    <= PLAY;
                        end
                    end
                    PLAY: begin
                        // A wrap coinciding with a new selection is not used;
                        // the change waits for the next one.
                        if (sel_new)           state <= CHANGE;
                        else if (all_released) state <= RELEASE;
                    end
                    CHANGE: begin
                        if (sel_new) begin
                            state <= CHANGE;
                        end else if (all_released) begin
                            state <= RELEASE;
                        end else if (vif.wrap_i) begin
                            note_q <= sel_q;
                            load_q <= 1'b1;
`ifdef PORTAMENTO_EN
                            period_q <= glide_next;
                            if (glide_next == target) state <= PLAY;
`else
                            period_q <= target;
                            state    <= PLAY;
`endif
                        end
                    end
                    RELEASE: begin
                        if (sel_new) begin
                            state <= CHANGE;
                        end else if (vif.wrap_i) begin
                            gate_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign vif.period_o = period_q;
    assign vif.note_o   = note_q;
    assign vif.gate_o   = gate_q;
    assign vif.load_o   = load_q;

endmodule

// File: tb/tb_voice_ctrl.sv
// -----------------------------------------------------------------------------
// tb_voice_ctrl
// Directed scenarios followed by randomized keypad/wrap/en/rst traffic; a
// behavioural model of the voice runs alongside and every cycle's outputs are
// compared against it. A few literal values pin the model's period table.
// -----------------------------------------------------------------------------
module tb_voice_ctrl;
    import synth_pkg::*;

    localparam int DEB = 4;

    logic tb_clk = 1'b0;
    logic rst;
    always #50 tb_clk = ~tb_clk;

    voice_ctrl_if vif ();

    voice_ctrl #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk (tb_clk),
        .rst (rst),
        .vif (vif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    int ref_period [NUM_KEYS];

    // Behavioural voice model
    logic [NUM_KEYS-1:0] hist [DEB+1];
    logic [NUM_KEYS-1:0] m_stable;
    logic [NUM_KEYS-1:0] m_prev;
    int m_tgt, m_period, m_note;
    bit m_gate, m_load, m_pend, m_rel;

    function automatic int top_key(input logic [NUM_KEYS-1:0] v);
        for (int i = NUM_KEYS - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [NUM_KEYS-1:0] key(input int k);
        logic [NUM_KEYS-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= DEB; i++) hist[i] = '0;
        m_stable = '0; m_prev = '0;
        m_tgt = 0; m_period = 0; m_note = 0;
        m_gate = 0; m_load = 0; m_pend = 0; m_rel = 0;
    endtask

    task automatic model_step();
        logic [NUM_KEYS-1:0] eff, rise;
        int sel;
        bit same;
        eff  = vif.en ? m_stable : '0;
        rise = eff & ~m_prev;
        sel  = -1;
        if (rise != '0) sel = top_key(rise);
        else if (eff != '0 && !eff[m_tgt]) sel = top_key(eff);

        m_load = 0;
        if (!vif.en) begin
            m_gate = 0; m_pend = 0; m_rel = 0;
        end else if (!m_gate) begin
            if (sel >= 0) begin
                m_gate = 1; m_period = ref_period[sel]; m_note = sel; m_load = 1;
            end
        end else if (sel >= 0) begin
            m_pend = 1; m_rel = 0;
        end else if (eff == '0) begin
            if (m_rel && vif.wrap_i) begin
                m_gate = 0; m_rel = 0;
            end else begin
                m_rel = 1; m_pend = 0;
            end
        end else if (m_pend && vif.wrap_i) begin
`ifdef PORTAMENTO_EN
            if (m_period < ref_period[m_tgt])
                m_period = (ref_period[m_tgt] - m_period > 64) ? m_period + 64 : ref_period[m_tgt];
            else
                m_period = (m_period - ref_period[m_tgt] > 64) ? m_period - 64 : ref_period[m_tgt];
            if (m_period == ref_period[m_tgt]) m_pend = 0;
`else
            m_period = ref_period[m_tgt];
            m_pend   = 0;
`endif
            m_note = m_tgt; m_load = 1;
        end
        if (sel >= 0) m_tgt = sel;
        m_prev = eff;

        // A raw value is accepted once it has been sampled DEB+1 times in a row.
        same = 1;
        for (int i = 1; i <= DEB; i++) if (hist[i] != hist[0]) same = 0;
        if (same) m_stable = hist[0];
        for (int i = DEB; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = vif.keypad_i;
    endtask

    always @(posedge tb_clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge tb_clk) begin
        if (chk_en) begin
            n_checks++;
            if (vif.period_o !== PERIOD_W'(m_period) || vif.note_o !== 4'(m_note) ||
                vif.gate_o !== m_gate || vif.load_o !== m_load) begin
                n_fail++;
                $display("FAIL model_compare t=%0t: got period=%0d note=%0d gate=%0b load=%0b, want period=%0d note=%0d gate=%0b load=%0b",
                         $time, vif.period_o, vif.note_o, vif.gate_o, vif.load_o,
                         m_period, m_note, m_gate, m_load);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge tb_clk);
            #1;
        end
    endtask

    task automatic wrap_pulse();
        vif.wrap_i = 1'b1;
        step(1);
        vif.wrap_i = 1'b0;
    endtask

    function automatic int out_word();
        return int'({vif.period_o, vif.note_o, vif.gate_o, vif.load_o});
    endfunction

    int lat, loads, hold, r, b;

    initial begin
        for (int i = 0; i < NUM_KEYS; i++)
            ref_period[i] = $rtoi(22728.0 * (2.0 ** ((9.0 - i) / 12.0)) + 0.5);

        rst = 1'b1;
        vif.en = 1'b0;
        vif.keypad_i = '0;
        vif.wrap_i = 1'b0;
        step(1);
        chk_en = 1;

        // 1: reset holds outputs at zero while inputs toggle
        for (int i = 0; i < 2; i++) begin
            vif.en = ~vif.en;
            vif.keypad_i = ~vif.keypad_i;
            step(1);
            check("reset_outputs_zero", out_word(), 0);
        end
        vif.keypad_i = '0;
        vif.en = 1'b0;
        rst = 1'b0;
        step(2);

        // 2: first press
        vif.en = 1'b1;
        vif.keypad_i = key(0);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step(1);
            if (vif.gate_o) lat = k;
        end
        check("press_latency", lat, 7);
        check("c4_period", vif.period_o, 38224);
        check("c4_note", vif.note_o, 0);
        check("c4_load", vif.load_o, 1);
        check("model_c4_period", m_period, 38224);
        step(1);
        check("load_single_cycle", vif.load_o, 0);

        // 3: second key waits for wrap
        vif.keypad_i = key(0) | key(12);
        step(9);
        check("hold_before_wrap", vif.period_o, 38224);
        wrap_pulse();
        check("c5_period", vif.period_o, 19112);
        check("c5_note", vif.note_o, 12);
        check("c5_load", vif.load_o, 1);
        check("model_c5_period", m_period, 19112);
        step(1);
        check("c5_load_end", vif.load_o, 0);

        // 4: fall back to held key, then release
        vif.keypad_i = key(0);
        step(9);
        check("fallback_pending", vif.period_o, 19112);
        wrap_pulse();
        check("fallback_period", vif.period_o, 38224);
        check("fallback_note", vif.note_o, 0);
        vif.keypad_i = '0;
        step(9);
        check("release_gate_held", vif.gate_o, 1);
        wrap_pulse();
        check("release_gate_off", vif.gate_o, 0);

        // 5: simultaneous press, then a short glitch
        vif.keypad_i = key(3) | key(9);
        step(9);
        check("chord_gate", vif.gate_o, 1);
        check("chord_note", vif.note_o, 9);
        check("chord_period", vif.period_o, 22728);
        check("model_a4_period", m_period, 22728);
        vif.keypad_i = key(3) | key(9) | key(5);
        step(3);
        vif.keypad_i = key(3) | key(9);
        loads = 0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            loads += int'(vif.load_o);
        end
        check("glitch_no_load", loads, 0);
        check("glitch_note", vif.note_o, 9);

        // 6: enable drop, re-enable, reset mid-change
        vif.en = 1'b0;
        step(1);
        check("en_off_gate", vif.gate_o, 0);
        vif.en = 1'b1;
        step(1);
        check("en_rise_gate", vif.gate_o, 1);
        check("en_rise_note", vif.note_o, 9);
        vif.keypad_i = key(3) | key(9) | key(12);
        step(9);
        check("change_pending_note", vif.note_o, 9);
        #10;
        rst = 1'b1;
        #1;
        check("rst_async_zero", out_word(), 0);
        step(1);
        vif.keypad_i = '0;
        rst = 1'b0;
        step(2);

        // Randomized traffic
        vif.en = 1'b1;
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 9);
                if (r == 0 || $countones(vif.keypad_i) > 4) begin
                    vif.keypad_i = '0;
                end else begin
                    b = $urandom_range(0, NUM_KEYS - 1);
                    vif.keypad_i[b] = ~vif.keypad_i[b];
                    if (r > 7) begin
                        b = $urandom_range(0, NUM_KEYS - 1);
                        vif.keypad_i[b] = ~vif.keypad_i[b];
                    end
                end
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            vif.wrap_i = ($urandom_range(0, 5) == 0);
            if (vif.en ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 9) == 0))
                vif.en = ~vif.en;
            rst = ($urandom_range(0, 999) == 0);
            step(1);
        end
        rst = 1'b0;
        vif.wrap_i = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
